// File: rtl/hpdmc_wrburst_ctl.sv
// DDR write-burst sequencer: latches one 4-beat burst, waits WL cycles, then drives ODDR2 DQ/DM/DQS with pre/postamble.
// Latency WL cycles accept-to-preamble, WL+4 cycles per burst; wr_ready low outside IDLE or while rd_busy holds DQ.
module hpdmc_wrburst_ctl #(
    parameter int WL = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_mask,
    input  logic        rd_busy,
    output logic [15:0] dq_d0,
    output logic [15:0] dq_d1,
    output logic [1:0]  dm_d0,
    output logic [1:0]  dm_d1,
    output logic        dqs_d0,
    output logic        dqs_d1,
    output logic        dq_oe,
    output logic        dqs_oe,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_PRE, S_BURST0, S_BURST1, S_POST
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_data;
    logic [7:0]  r_mask;
    logic        w_accept;

    logic [15:0] w_dq_d0, w_dq_d1;
    logic [1:0]  w_dm_d0, w_dm_d1;
    logic        w_dqs_d0, w_dq_oe, w_dqs_oe, w_done;

    assign wr_ready = (r_state == S_IDLE) && !rd_busy && !sys_rst;
    assign w_accept = wr_valid && wr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = 3'(WL - 1);
                    w_state_nxt = (WL > 1) ? S_WAIT : S_PRE;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1)
                    w_state_nxt = S_PRE;
            end
            S_PRE:    w_state_nxt = S_BURST0;
            S_BURST0: w_state_nxt = S_BURST1;
            S_BURST1: w_state_nxt = S_POST;
            S_POST:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        w_dq_d0  = '0;
        w_dq_d1  = '0;
        w_dm_d0  = '0;
        w_dm_d1  = '0;
        w_dqs_d0 = 1'b0;
        w_dq_oe  = 1'b0;
        w_dqs_oe = 1'b0;
        w_done   = 1'b0;
        case (w_state_nxt)
            S_PRE: w_dqs_oe = 1'b1;
            S_BURST0: begin
                w_dq_oe  = 1'b1;
                w_dqs_oe = 1'b1;
                w_dqs_d0 = 1'b1;
                w_dq_d0  = r_data[15:0];
                w_dq_d1  = r_data[31:16];
                w_dm_d0  = r_mask[1:0];
                w_dm_d1  = r_mask[3:2];
            end
            S_BURST1: begin
                w_dq_oe  = 1'b1;
                w_dqs_oe = 1'b1;
                w_dqs_d0 = 1'b1;
                w_dq_d0  = r_data[47:32];
                w_dq_d1  = r_data[63:48];
                w_dm_d0  = r_mask[5:4];
                w_dm_d1  = r_mask[7:6];
            end
            S_POST: begin
                w_dqs_oe = 1'b1;
                w_done   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            dq_d0   <= '0;
            dq_d1   <= '0;
            dm_d0   <= '0;
            dm_d1   <= '0;
            dqs_d0  <= 1'b0;
            dqs_d1  <= 1'b0;
            dq_oe   <= 1'b0;
            dqs_oe  <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_data <= wr_data;
                r_mask <= wr_mask;
            end
            dq_d0  <= w_dq_d0;
            dq_d1  <= w_dq_d1;
            dm_d0  <= w_dm_d0;
            dm_d1  <= w_dm_d1;
            dqs_d0 <= w_dqs_d0;
            dqs_d1 <= 1'b0;
            dq_oe  <= w_dq_oe;
            dqs_oe <= w_dqs_oe;
            done   <= w_done;
        end
    end

endmodule

// File: tb/tb_hpdmc_wrburst_ctl.sv
// Bench for hpdmc_wrburst_ctl: two instances (WL=2, WL=1) checked every cycle against a timeline model.
module tb_hpdmc_wrburst_ctl;

    logic        clk;
    logic        rst   [2];
    logic        valid [2];
    logic        rdy   [2];
    logic [63:0] data  [2];
    logic [7:0]  mask  [2];
    logic        busy  [2];
    logic [15:0] dq_d0 [2];
    logic [15:0] dq_d1 [2];
    logic [1:0]  dm_d0 [2];
    logic [1:0]  dm_d1 [2];
    logic        dqs_d0[2];
    logic        dqs_d1[2];
    logic        dq_oe [2];
    logic        dqs_oe[2];
    logic        done  [2];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each lane remembers the edge of its last accept and the latched burst.
    int          e;
    bit          act [2];
    int          t0  [2];
    logic [63:0] md  [2];
    logic [7:0]  mm  [2];
    bit          er  [2];

    hpdmc_wrburst_ctl #(.WL(2)) u_wl2 (
        .sys_clk(clk), .sys_rst(rst[0]), .wr_valid(valid[0]), .wr_ready(rdy[0]),
        .wr_data(data[0]), .wr_mask(mask[0]), .rd_busy(busy[0]),
        .dq_d0(dq_d0[0]), .dq_d1(dq_d1[0]), .dm_d0(dm_d0[0]), .dm_d1(dm_d1[0]),
        .dqs_d0(dqs_d0[0]), .dqs_d1(dqs_d1[0]), .dq_oe(dq_oe[0]), .dqs_oe(dqs_oe[0]),
        .done(done[0])
    );

    hpdmc_wrburst_ctl #(.WL(1)) u_wl1 (
        .sys_clk(clk), .sys_rst(rst[1]), .wr_valid(valid[1]), .wr_ready(rdy[1]),
        .wr_data(data[1]), .wr_mask(mask[1]), .rd_busy(busy[1]),
        .dq_d0(dq_d0[1]), .dq_d1(dq_d1[1]), .dm_d0(dm_d0[1]), .dm_d1(dm_d1[1]),
        .dqs_d0(dqs_d0[1]), .dqs_d1(dqs_d1[1]), .dq_oe(dq_oe[1]), .dqs_oe(dqs_oe[1]),
        .done(done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    endtask

    function automatic int wl_of(input int l);
        return (l == 0) ? 2 : 1;
    endfunction

    function automatic bit exp_idle(input int l);
        return !act[l] || (e - t0[l] + 1 >= wl_of(l) + 4);
    endfunction

    // Packed {dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe, dqs_oe, done}.
    function automatic logic [40:0] exp_out(input int l);
        logic [15:0] a, b;
        logic [1:0]  ma, mb;
        logic        s0, qoe, soe, dn;
        int          d, w;
        a = '0; b = '0; ma = '0; mb = '0; s0 = 0; qoe = 0; soe = 0; dn = 0;
        w = wl_of(l);
        d = e - t0[l] + 1;
        if (act[l]) begin
            if (d == w) begin
                soe = 1;
            end else if (d == w + 1) begin
                qoe = 1; soe = 1; s0 = 1;
                a = md[l][15:0];  b = md[l][31:16];
                ma = mm[l][1:0];  mb = mm[l][3:2];
            end else if (d == w + 2) begin
                qoe = 1; soe = 1; s0 = 1;
                a = md[l][47:32]; b = md[l][63:48];
                ma = mm[l][5:4];  mb = mm[l][7:6];
            end else if (d == w + 3) begin
                soe = 1; dn = 1;
            end
        end
        return {a, b, ma, mb, s0, 1'b0, qoe, soe, dn};
    endfunction

    task automatic step();
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            er[l] = !rst[l] && !busy[l] && exp_idle(l);
            chk($sformatf("rdy%0d", l), 64'(rdy[l]), 64'(er[l]));
            chk($sformatf("out%0d", l),
                64'({dq_d0[l], dq_d1[l], dm_d0[l], dm_d1[l], dqs_d0[l], dqs_d1[l],
                     dq_oe[l], dqs_oe[l], done[l]}),
                64'(exp_out(l)));
        end
        @(posedge clk);
        e++;
        for (int l = 0; l < 2; l++) begin
            if (rst[l]) begin
                act[l] = 0;
            end else if (valid[l] && er[l]) begin
                act[l] = 1;
                t0[l]  = e;
                md[l]  = data[l];
                mm[l]  = mask[l];
            end
        end
        #1;
    endtask

    task automatic set_all(input logic r, input logic v, input logic b);
        for (int l = 0; l < 2; l++) begin
            rst[l] = r; valid[l] = v; busy[l] = b;
        end
    endtask

    initial begin
        e = 0;
        for (int l = 0; l < 2; l++) begin
            act[l] = 0; t0[l] = 0; md[l] = '0; mm[l] = '0; er[l] = 0;
            data[l] = '0; mask[l] = '0;
        end
        set_all(1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        valid[0] = 1'b1; valid[1] = 1'b1;
        repeat (2) step();

        // Basic burst on both lanes; data is scribbled over right after accept.
        set_all(1'b0, 1'b1, 1'b0);
        data[0] = 64'h4444_3333_2222_1111; mask[0] = 8'h00;
        data[1] = {$urandom, $urandom};     mask[1] = 8'hA5;
        step();
        valid[0] = 1'b0; valid[1] = 1'b0;
        data[0] = '1; data[1] = '1;
        step();
        chk("pre_dqs_oe", 64'(dqs_oe[0]), 64'd1);
        chk("pre_dq_oe", 64'(dq_oe[0]), 64'd0);
        chk("wl1_dm_b0", 64'({dm_d0[1], dm_d1[1]}), 64'h5);
        step();
        chk("beat0", 64'({dq_d0[0], dq_d1[0]}), 64'h1111_2222);
        chk("wl1_dm_b1", 64'({dm_d0[1], dm_d1[1]}), 64'hA);
        step();
        chk("beat1", 64'({dq_d0[0], dq_d1[0]}), 64'h3333_4444);
        repeat (6) step();

        // rd_busy blocks accept, then back-to-back bursts with valid held.
        set_all(1'b0, 1'b1, 1'b1);
        repeat (5) step();
        set_all(1'b0, 1'b1, 1'b0);
        repeat (14) step();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (8) step();

        // Reset during lane 0's BURST0.
        set_all(1'b0, 1'b1, 1'b0);
        step();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (2) step();
        set_all(1'b1, 1'b0, 1'b0);
        step();
        set_all(1'b0, 1'b0, 1'b0);
        chk("rst_abort", 64'({dq_oe[0], dqs_oe[0], done[0], dq_d0[0]}), 64'd0);
        repeat (3) step();
        set_all(1'b0, 1'b1, 1'b0);
        step();
        set_all(1'b0, 1'b0, 1'b0);
        repeat (8) step();

        // Randomized traffic.
        repeat (2000) begin
            for (int l = 0; l < 2; l++) begin
                valid[l] = ($urandom % 4) != 0;
                busy[l]  = ($urandom % 5) == 0;
                rst[l]   = ($urandom % 97) == 0;
                data[l]  = {$urandom, $urandom};
                mask[l]  = 8'($urandom);
            end
            step();
        end
        set_all(1'b0, 1'b0, 1'b0);
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hpdmc_wrburst_ctl.md
# hpdmc_wrburst_ctl

Write-burst sequencer for the 16-bit DDR SDRAM data output path. It accepts one burst-of-4 write (64 data bits, 8 byte-mask bits) per handshake and waits a fixed write latency. It then drives the rising/falling-edge data, mask and DQS inputs of the ODDR2 output registers, plus their output enables, with preamble and postamble. It sits between the HPDMC command scheduler and the DQ/DM/DQS ODDR2 banks; the read path signals bus ownership through `rd_busy`.

## Interface
Parameters:
- `WL`, 2, write latency in sys_clk cycles from accept to preamble; legal range 1..7.

Ports:
- `sys_clk` in 1: sole clock; all logic on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: write burst request.
- `wr_ready` out 1: block can accept a request.
- `wr_data` in 64: burst data; beat i = bits [16i+15:16i].
- `wr_mask` in 8: byte masks, 1 = masked; beat i = bits [2i+1:2i].
- `rd_busy` in 1: read path owns DQ; blocks new accepts.
- `dq_d0`, `dq_d1` out 16: ODDR2 D0/D1 for DQ.
- `dm_d0`, `dm_d1` out 2: ODDR2 D0/D1 for DM.
- `dqs_d0`, `dqs_d1` out 1: ODDR2 D0/D1 for DQS.
- `dq_oe` out 1: DQ/DM output enable.
- `dqs_oe` out 1: DQS output enable.
- `done` out 1: one-cycle pulse when a burst completes.

## Operation
- States: IDLE, WAIT, PRE, BURST0, BURST1, POST.
- `wr_ready` = (state==IDLE) && !rd_busy && !sys_rst, combinational.
- Accept: `wr_valid && wr_ready` sampled at an edge.
  - At that edge, latch `wr_data`/`wr_mask` into holding registers.
  - Load the latency counter with WL-1.
  - Next state: WAIT if WL>1, else PRE.
- WAIT: decrement the counter each cycle; go to PRE when it reaches 0 (WL-1 cycles total in WAIT).
- PRE → BURST0 → BURST1 → POST → IDLE, one cycle each.
- All data/control outputs are registered and reflect the current state. The holding registers are copied into the output registers on the edge that enters the state.
- Outputs per state:
  - IDLE/WAIT: everything 0.
  - PRE: `dqs_oe`=1, `dqs_d0`=`dqs_d1`=0, `dq_oe`=0.
  - BURST0: `dq_oe`=`dqs_oe`=1; `dq_d0`=beat0, `dq_d1`=beat1; `dm_d0`=mask beat0, `dm_d1`=mask beat1; `dqs_d0`=1, `dqs_d1`=0.
  - BURST1: same enables; beats 2/3 and their masks; `dqs_d0`=1, `dqs_d1`=0.
  - POST: `dqs_oe`=1, `dqs_d0`=`dqs_d1`=0, `dq_oe`=0, dq/dm = 0, `done`=1.
- Boundary conditions:
  - `rd_busy` rising after accept is ignored. A burst is never aborted except by reset.
  - `wr_valid` outside IDLE is not acknowledged; the requester holds its request.
  - `wr_data`/`wr_mask` changes after accept have no effect.
  - Reset mid-burst: next edge forces IDLE and zeros all outputs including `dq_oe`/`dqs_oe`. The counter clears, no `done` is issued, and latched data is discarded.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. `wr_ready` is 0 while `sys_rst` is high and 1 in the first cycle after reset if `rd_busy`=0.
- Cycle n = interval after edge n; accept at edge 0:
  - cycles 1..WL-1: WAIT
  - cycle WL: PRE
  - cycle WL+1: BURST0
  - cycle WL+2: BURST1
  - cycle WL+3: POST, `done`=1
  - cycle WL+4: IDLE, `wr_ready` high again
- Throughput: one burst per WL+4 cycles. The earliest next accept is edge WL+4.
- `dq_oe` is high exactly 2 cycles per burst. `dqs_oe` is high exactly 4 cycles and strictly encloses `dq_oe` by one cycle on each side.
- `done` is high exactly 1 cycle per completed burst.

## Test plan
- WL=2: accept data 0x4444_3333_2222_1111, mask 0x00 at edge 0.
  - PRE in cycle 2 with `dqs_oe`=1, `dq_oe`=0.
  - Cycle 3: `dq_d0`=0x1111, `dq_d1`=0x2222. Cycle 4: 0x3333 / 0x4444.
  - `done` in cycle 5; `wr_ready`=1 in cycle 6.
- WL=1 with mask 0xA5: WAIT skipped, PRE in cycle 1.
  - `dm_d0`/`dm_d1` = 01/01 in cycle 2, then 10/10 in cycle 3.
- Hold `rd_busy`=1 with `wr_valid`=1 for 5 cycles: `wr_ready`=0 and no state change. Release: accept at the first edge with `rd_busy`=0.
- Back-to-back: `wr_valid` held high for two bursts with WL=2.
  - Second accept at edge 6.
  - `dq_oe` pulses in cycles 3–4 and 9–10; `done` in cycles 5 and 11.
- Assert `sys_rst` for 1 cycle during BURST0: next cycle all outputs 0, state IDLE, no `done`. A new accept works normally.
- Change `wr_data` to 0xFFFF… in the cycle after accept: the output beats still carry the originally latched values.
